// File: rtl/pll_sup_pkg.sv
// Shared types and defaults for the PLL lock supervisor.
package pll_sup_pkg;

    // Supervisor states
    typedef enum logic [2:0] {
        HOLD,
        WAIT_LOCK,
        SETTLE,
        RUN,
        FAULT
    } sup_state_e;

    // Defaults sized for a 50 MHz reference clock
    localparam int unsigned DEF_RST_HOLD_CYCLES     = 500;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1000;
    localparam int unsigned DEF_MAX_RETRIES         = 7;

    // Width of relock_count and of the retry counter
    localparam int unsigned RELOCK_W = 8;

    // Largest of three cycle counts, used to size the shared counter
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_bit_sync.sv
// Two-flop synchroniser with synchronous active-high clear.
module bit_sync (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (clr) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: sequences the PLL reset, qualifies lock,
// retries failed attempts, and releases a clean downstream reset.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                pll_locked,
    input  logic                fault_clear,
    output logic                pll_rst,
    output logic                sys_rst,
    output logic                ready,
    output logic                fault,
    output logic [RELOCK_W-1:0] relock_count
);

    localparam int unsigned CNT_MAX = max3(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES,
                                           LOCK_STABLE_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0]    HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]    STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RELOCK_W-1:0] RETRY_LIMIT  = RELOCK_W'(MAX_RETRIES);

    sup_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RELOCK_W-1:0] retries_q, retries_d;
    logic [RELOCK_W-1:0] relock_q, relock_d;
    logic [RELOCK_W-1:0] retries_inc;
    logic                locked_s;

    bit_sync u_lock_sync (
        .clk (refclk),
        .clr (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    assign retries_inc = retries_q + RELOCK_W'(1);

    // State, counter, retry and relock registers
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            retries_q <= '0;
            relock_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
            relock_q  <= relock_d;
        end
    end

    // Next-state logic; the counter only advances in timed states so it never wraps
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retries_d = retries_q;
        relock_d  = relock_q;
        unique case (state_q)
            HOLD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == HOLD_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (locked_s) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retries_d = retries_inc;
                    cnt_d     = '0;
                    state_d   = (retries_inc == RETRY_LIMIT) ? FAULT : HOLD;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A lock drop takes precedence over completing the settle window
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    retries_d = '0;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    if (relock_q != '1) relock_d = relock_q + RELOCK_W'(1);
                end
            end
            FAULT: begin
                if (fault_clear) begin
                    state_d   = HOLD;
                    cnt_d     = '0;
                    retries_d = '0;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    // Moore output decode from the registered state
    always_comb begin
        pll_rst = 1'b1;
        sys_rst = 1'b1;
        ready   = 1'b0;
        fault   = 1'b0;
        unique case (state_q)
            HOLD:      pll_rst = 1'b1;
            WAIT_LOCK: pll_rst = 1'b0;
            SETTLE:    pll_rst = 1'b0;
            RUN: begin
                pll_rst = 1'b0;
                sys_rst = 1'b0;
                ready   = 1'b1;
            end
            FAULT:     fault = 1'b1;
            default:   pll_rst = 1'b1;
        endcase
    end

    assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters.
module tb_pll_lock_supervisor;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       fault_clear = 1'b0;
    logic       pll_rst, sys_rst, ready, fault;
    logic [7:0] relock_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    pll_lock_supervisor #(
        .RST_HOLD_CYCLES     (4),
        .LOCK_TIMEOUT_CYCLES (20),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRIES         (2)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .fault_clear  (fault_clear),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .fault        (fault),
        .relock_count (relock_count)
    );

    always #5 refclk = ~refclk;

    // One active edge, then sample on the falling edge; cyc = edges since release
    task automatic step();
        @(posedge refclk);
        @(negedge refclk);
        cyc++;
    endtask

    task automatic reset_dut(input logic lock);
        rst = 1'b1;
        pll_locked = lock;
        fault_clear = 1'b0;
        repeat (3) @(posedge refclk);
        @(negedge refclk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        logic [11:0] obs, exp;
        reset_dut(1'b0);
        obs = {pll_rst, sys_rst, ready, fault, relock_count};
        exp = {4'b1100, 8'd0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL reset_values got=%h want=%h", obs, exp);
        end
    endtask

    task automatic test_lock_immediate();
        logic [3:0] obs, exp;
        reset_dut(1'b1);
        for (int k = 1; k <= 15; k++) begin
            step();
            exp = {(cyc < 4), (cyc < 13), (cyc >= 13), 1'b0};
            obs = {pll_rst, sys_rst, ready, fault};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL lock_imm cyc=%0d got=%b want=%b", cyc, obs, exp);
            end
        end
    endtask

    task automatic test_no_lock_fault();
        logic [3:0] obs, exp;
        logic       p;
        reset_dut(1'b0);
        for (int k = 1; k <= 52; k++) begin
            step();
            p = (cyc <= 3) || (cyc >= 24 && cyc <= 27) || (cyc >= 48);
            exp = {p, 1'b1, 1'b0, (cyc >= 48)};
            obs = {pll_rst, sys_rst, ready, fault};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL no_lock cyc=%0d got=%b want=%b", cyc, obs, exp);
            end
        end
        // Clear fault: sequence restarts exactly as from reset, retries cleared
        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
        for (int j = 0; j <= 49; j++) begin
            p = (j <= 3) || (j >= 24 && j <= 27) || (j >= 48);
            exp = {p, 1'b1, 1'b0, (j >= 48)};
            obs = {pll_rst, sys_rst, ready, fault};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL fault_clear j=%0d got=%b want=%b", j, obs, exp);
            end
            step();
        end
    endtask

    task automatic test_glitch();
        logic [1:0] obs, exp;
        reset_dut(1'b0);
        repeat (4) step();
        for (int k = 0; k < 22; k++) begin
            pll_locked = (cyc != 9);
            step();
            exp = {(cyc >= 21), (cyc < 21)};
            obs = {ready, sys_rst};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL glitch cyc=%0d got=%b want=%b", cyc, obs, exp);
            end
        end
    endtask

    task automatic test_relock();
        logic [10:0] obs, exp;
        logic        s;
        pll_locked = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            step();
            s = (k >= 3) && (k < 16);
            exp = {(k >= 3 && k <= 6), s, ~s, ((k >= 3) ? 8'd1 : 8'd0)};
            obs = {pll_rst, sys_rst, ready, relock_count};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL relock k=%0d got=%h want=%h", k, obs, exp);
            end
            if (k == 3) pll_locked = 1'b1;
        end
    endtask

    task automatic test_saturation();
        logic [8:0] obs, exp;
        int         want;
        for (int i = 0; i < 299; i++) begin
            pll_locked = 1'b0;
            repeat (3) step();
            pll_locked = 1'b1;
            repeat (13) step();
            want = (i + 2 > 255) ? 255 : i + 2;
            exp = {1'b1, 8'(want)};
            obs = {ready, relock_count};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL saturate i=%0d got=%h want=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_fault_clear_in_run();
        logic [11:0] obs, exp;
        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp = {4'b0010, 8'd255};
            obs = {pll_rst, sys_rst, ready, fault, relock_count};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL clear_in_run k=%0d got=%h want=%h", k, obs, exp);
            end
            step();
        end
    endtask

    task automatic test_rst_mid_settle();
        logic [11:0] obs, exp;
        pll_locked = 1'b0;
        repeat (3) step();
        pll_locked = 1'b1;
        repeat (6) step();
        n_cmp++;
        if (ready !== 1'b0 || pll_rst !== 1'b0) begin
            n_bad++;
            $display("FAIL pre_settle got=%b%b want=00", ready, pll_rst);
        end
        rst = 1'b1;
        step();
        exp = {4'b1100, 8'd0};
        obs = {pll_rst, sys_rst, ready, fault, relock_count};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL rst_mid_settle got=%h want=%h", obs, exp);
        end
        rst = 1'b0;
        cyc = 0;
        repeat (13) step();
        obs = {pll_rst, sys_rst, ready, fault, relock_count};
        exp = {4'b0010, 8'd0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL restart got=%h want=%h", obs, exp);
        end
    endtask

    initial begin
        test_reset();
        test_lock_immediate();
        test_no_lock_fault();
        test_glitch();
        test_relock();
        test_saturation();
        test_fault_clear_in_run();
        test_rst_mid_settle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Reset and lock supervisor on the control side of the video PLL. Runs on the 50 MHz reference clock: drives the PLL reset, takes the PLL's asynchronous `locked` flag, and waits until lock has been stable before it releases a clean reset to downstream logic. It retries a PLL that fails to lock, counts loss-of-lock events, and latches a fault after repeated failures. The pixel-clock domain re-synchronises `sys_rst` locally.

## Interface
- `RST_HOLD_CYCLES`, 500: cycles `pll_rst` is held high per attempt (10 µs at 50 MHz).
- `LOCK_TIMEOUT_CYCLES`, 50000: cycles to wait for lock before retrying (1 ms).
- `LOCK_STABLE_CYCLES`, 1000: consecutive synchronised-lock cycles required before release.
- `MAX_RETRIES`, 7: failed attempts before FAULT; range 1..255.
- `refclk`  in  1  reference clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `pll_locked`  in  1  PLL lock flag; asynchronous, synchronised internally.
- `fault_clear`  in  1  single-cycle pulse; leaves FAULT.
- `pll_rst`  out  1  reset to the PLL.
- `sys_rst`  out  1  active-high downstream reset, `refclk` domain.
- `ready`  out  1  high only in RUN.
- `fault`  out  1  high only in FAULT.
- `relock_count`  out  8  RUN-state lock losses; saturates at 255.

## Operation
- Synchronise `pll_locked` with a 2-flop synchroniser to produce `locked_s`. `rst` clears both flops.
- All outputs are Moore, decoded from registered state. Reset values: `pll_rst`=1, `sys_rst`=1, `ready`=0, `fault`=0, `relock_count`=0. Reset also sets state=HOLD, cnt=0, retries=0.
- **HOLD**
  - Outputs: `pll_rst`=1, `sys_rst`=1.
  - cnt counts 0..RST_HOLD_CYCLES-1, then go to WAIT_LOCK with cnt=0.
- **WAIT_LOCK**
  - Outputs: `pll_rst`=0, `sys_rst`=1.
  - `locked_s`=1: go to SETTLE with cnt=0.
  - Else, at cnt=LOCK_TIMEOUT_CYCLES-1: retries+1. If the new value equals MAX_RETRIES, go to FAULT; otherwise go to HOLD.
- **SETTLE**
  - Outputs: `pll_rst`=0, `sys_rst`=1.
  - `locked_s`=0: go to WAIT_LOCK with cnt=0. The timeout restarts and retries is unchanged.
  - Else, at cnt=LOCK_STABLE_CYCLES-1: go to RUN and clear retries.
- **RUN**
  - Outputs: `pll_rst`=0, `sys_rst`=0, `ready`=1.
  - `locked_s`=0: go to HOLD with cnt=0 and increment `relock_count` (saturating).
- **FAULT**
  - Outputs: `pll_rst`=1, `sys_rst`=1, `fault`=1.
  - `fault_clear`=1: go to HOLD with cnt=0 and retries=0.
- Priority and boundary rules:
  - `rst` has priority over everything.
  - `fault_clear` is ignored outside FAULT.
  - If lock drops on the same cycle SETTLE would complete, the drop wins.
  - `rst` in any state, including mid-SETTLE or mid-RUN, returns immediately to reset values. `relock_count` is cleared.
- Width of cnt: $clog2 of the maximum of the three cycle parameters, plus 1. Compare with `==` only; cnt never wraps.

## Timing
- Pin to `locked_s`: 2 cycles. A `locked_s` change is reflected in the outputs 1 cycle later. Pin drop in RUN to `sys_rst`=1: 3 cycles.
- Cycle 0 is the first edge with `rst`=0. If the PLL locks immediately:
  - `pll_rst` falls at cycle RST_HOLD_CYCLES.
  - `ready` rises and `sys_rst` falls at cycle RST_HOLD_CYCLES+1+LOCK_STABLE_CYCLES (1501 with defaults).
- Each failed attempt lasts RST_HOLD_CYCLES+LOCK_TIMEOUT_CYCLES cycles.

## Structure
- Package `pll_sup_pkg` holds:
  - state enum {HOLD, WAIT_LOCK, SETTLE, RUN, FAULT};
  - default parameter constants;
  - the `relock_count` width constant (8).
- One sub-module, `bit_sync`: a 2-flop synchroniser with synchronous active-high clear. Everything else (FSM, cnt, retries, outputs) stays in the top.

## Test plan
Bench parameters: RST_HOLD=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=2.
- `pll_locked` tied 1, release `rst` -> `pll_rst` falls at cycle 4; `ready`=1 and `sys_rst`=0 at cycle 13; `fault`=0.
- `pll_locked` tied 0 -> `pll_rst` high at cycles 0-3 and 24-27; `fault`=1 at cycle 48 with `pll_rst`=1. A `fault_clear` pulse -> HOLD, `pll_rst`=1 for 4 cycles.
- Lock rises, holds 5 cycles, drops 1 cycle, then returns -> `ready` never asserts during the glitch. `ready` asserts 9 cycles after `locked_s` returns (1 WAIT_LOCK cycle + 8 SETTLE cycles).
- In RUN, drop `pll_locked` -> `sys_rst`=1 and `ready`=0 exactly 3 cycles later; `relock_count` goes 0 to 1; `pll_rst` high 4 cycles. With lock restored, `ready` returns after another 9 cycles.
- 300 lock-loss/relock cycles -> `relock_count` stops at 255 and does not wrap.
- `rst` pulsed mid-SETTLE, and `fault_clear` pulsed during RUN -> the first gives reset values on the next edge with `relock_count`=0; the second has no effect.
